// File: rtl/afu_pkg.sv
// Shared AFU definitions: engine state encoding, cache-line width and the
// read request record used by the read and write engines.
package afu_pkg;

    localparam int CL_WIDTH   = 512;
    localparam int AFU_ADDR_W = 32;
    localparam int AFU_TAG_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } afu_state_e;

    typedef struct packed {
        logic [AFU_ADDR_W-1:0] addr;
        logic [AFU_TAG_W-1:0]  tag;
    } rd_req_t;

endpackage

// File: rtl/afu_read_engine_if.sv
// Bus bundle between the read engine, the memory read port and the input
// FIFO. master = engine side, slave = memory/FIFO side.
interface afu_read_engine_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int TAG_WIDTH       = 8,
    parameter int BUFF_DEPTH_BITS = 3
);
    import afu_pkg::*;

    logic                       rd_req_valid;
    logic                       rd_req_ready;
    logic [ADDR_WIDTH-1:0]      rd_req_addr;
    logic [TAG_WIDTH-1:0]       rd_req_tag;
    logic                       rd_rsp_valid;
    logic [TAG_WIDTH-1:0]       rd_rsp_tag;
    logic [CL_WIDTH-1:0]        rd_rsp_data;
    logic [CL_WIDTH-1:0]        input_fifo_din;
    logic                       input_fifo_we;
    logic                       input_fifo_full;
    logic [BUFF_DEPTH_BITS-1:0] input_fifo_count;

    modport master (
        output rd_req_valid, rd_req_addr, rd_req_tag,
        input  rd_req_ready,
        input  rd_rsp_valid, rd_rsp_tag, rd_rsp_data,
        output input_fifo_din, input_fifo_we,
        input  input_fifo_full, input_fifo_count
    );

    modport slave (
        input  rd_req_valid, rd_req_addr, rd_req_tag,
        output rd_req_ready,
        output rd_rsp_valid, rd_rsp_tag, rd_rsp_data,
        input  input_fifo_din, input_fifo_we,
        output input_fifo_full, input_fifo_count
    );

endinterface

// File: rtl/afu_credit_counter.sv
// Outstanding-read counter. A read holds its credit from request transfer
// until its line is written into the FIFO; credit_ok says one more read
// can be issued without ever overflowing the FIFO.
module afu_credit_counter #(
    parameter int BUFF_DEPTH_BITS = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       inc,
    input  logic                       dec,
    input  logic [BUFF_DEPTH_BITS-1:0] fifo_count,
    output logic [BUFF_DEPTH_BITS:0]   outstanding,
    output logic                       credit_ok
);
    localparam int CNT_W = BUFF_DEPTH_BITS + 1;
    localparam int SUM_W = BUFF_DEPTH_BITS + 2;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] need;

    // Up/down update; simultaneous inc and dec cancel out.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dec && !inc) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign need        = SUM_W'(cnt_q) + SUM_W'(fifo_count) + SUM_W'(1);
    assign credit_ok   = need < SUM_W'(2 ** BUFF_DEPTH_BITS);
    assign outstanding = cnt_q;

endmodule

// File: rtl/afu_read_engine.sv
// AFU read engine: walks a job of cache lines, issues one read per line
// under FIFO credit control and forwards in-order responses into the
// input FIFO with one cycle of latency.
// Optional: define AFU_READ_TAG_CHECK_EN to add the expected-tag check and
// the sticky tag_err output.
module afu_read_engine
    import afu_pkg::*;
#(
    parameter int ADDR_WIDTH      = AFU_ADDR_W,
    parameter int TAG_WIDTH       = AFU_TAG_W,
    parameter int BUFF_DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] ctx_base_addr,
    input  logic [31:0]           ctx_length,
    afu_read_engine_if.master     bus,
    output logic                  busy,
    output logic                  done
`ifdef AFU_READ_TAG_CHECK_EN
    ,
    output logic                  tag_err
`endif
);

    afu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [31:0]           len_q, len_d;
    logic [31:0]           issued_q, issued_d;
    logic [31:0]           received_q, received_d;
    logic [CL_WIDTH-1:0]   din_q, din_d;
    logic                  we_q, we_d;
    logic                  done_q, done_d;

    logic                       start_ok;
    logic                       req_fire;
    logic                       rsp_take;
    logic                       credit_ok;
    logic [BUFF_DEPTH_BITS:0]   outstanding;

    assign start_ok = (state_q == IDLE) && start;
    assign rsp_take = ((state_q == RUN) || (state_q == DRAIN)) && bus.rd_rsp_valid;

    assign bus.rd_req_valid = (state_q == RUN) && (issued_q < len_q) &&
                              credit_ok && !bus.input_fifo_full;
    assign req_fire         = bus.rd_req_valid && bus.rd_req_ready;
    assign bus.rd_req_addr  = addr_q;
    assign bus.rd_req_tag   = tag_q;
    assign bus.input_fifo_din = din_q;
    assign bus.input_fifo_we  = we_q;
    assign busy = (state_q == RUN) || (state_q == DRAIN);
    assign done = done_q;

    afu_credit_counter #(
        .BUFF_DEPTH_BITS(BUFF_DEPTH_BITS)
    ) u_credit (
        .clk        (clk),
        .reset      (reset),
        .clr        (start_ok),
        .inc        (req_fire),
        .dec        (we_q),
        .fifo_count (bus.input_fifo_count),
        .outstanding(outstanding),
        .credit_ok  (credit_ok)
    );

    // Job sequencing, request issue and response capture.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tag_d      = tag_q;
        len_d      = len_q;
        issued_d   = issued_q;
        received_d = received_q;
        din_d      = din_q;
        we_d       = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (ctx_length == 32'd0) begin
                        state_d = DONE;
                    end else begin
                        addr_d     = ctx_base_addr;
                        len_d      = ctx_length;
                        tag_d      = '0;
                        issued_d   = '0;
                        received_d = '0;
                        state_d    = RUN;
                    end
                end
            end
            RUN: begin
                if (req_fire) begin
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                    tag_d    = tag_q + TAG_WIDTH'(1);
                    issued_d = issued_q + 32'd1;
                end
                if (issued_q == len_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((received_q == len_q) && (outstanding == '0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Responses only count while a job is live; in IDLE/DONE they are dropped.
        if (rsp_take) begin
            din_d      = bus.rd_rsp_data;
            we_d       = 1'b1;
            received_d = received_q + 32'd1;
        end
    end

    // Engine registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            tag_q      <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            din_q      <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tag_q      <= tag_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            din_q      <= din_d;
            we_q       <= we_d;
            done_q     <= done_d;
        end
    end

`ifdef AFU_READ_TAG_CHECK_EN
    logic [TAG_WIDTH-1:0] exp_tag_q, exp_tag_d;
    logic                 tag_err_q, tag_err_d;

    // Track the tag each in-order response should carry; latch any mismatch.
    always_comb begin
        exp_tag_d = exp_tag_q;
        tag_err_d = tag_err_q;
        if (start_ok) begin
            exp_tag_d = '0;
            tag_err_d = 1'b0;
        end else if (rsp_take) begin
            exp_tag_d = exp_tag_q + TAG_WIDTH'(1);
            if (bus.rd_rsp_tag != exp_tag_q) begin
                tag_err_d = 1'b1;
            end
        end
    end

    // Tag check registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_tag_q <= '0;
            tag_err_q <= 1'b0;
        end else begin
            exp_tag_q <= exp_tag_d;
            tag_err_q <= tag_err_d;
        end
    end

    assign tag_err = tag_err_q;
`else
    logic unused_rsp_tag;
    assign unused_rsp_tag = ^bus.rd_rsp_tag;
`endif

    // Credits must make a write into a full FIFO impossible.
    fifo_no_overflow_a: assert property (@(posedge clk) disable iff (!reset)
        !(we_q && bus.input_fifo_full));

endmodule

// File: doc/afu_read_engine.md
Name: afu_read_engine

Overview:
- Upstream feeder of the AFU user block's input FIFO.
- Takes a job (base cache-line address, length in lines) and issues one 512-bit read request per cache line to the memory interface.
- Accepts in-order read responses and writes each returned line into the input FIFO.
- Throttles issue with credits derived from FIFO occupancy plus reads still in flight, so the FIFO never overflows.

Parameters:
- ADDR_WIDTH, 32, cache-line address width; addresses are in line units, increment by 1.
- TAG_WIDTH, 8, read request/response tag width.
- BUFF_DEPTH_BITS, 3, log2 of the downstream input FIFO depth; must match the FIFO instance.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous reset, active low
- start  input  1  one-cycle job start pulse; honoured only in IDLE
- ctx_base_addr  input  ADDR_WIDTH  first line address, sampled on start
- ctx_length  input  32  number of lines, sampled on start
- rd_req_valid  output  1  read request valid
- rd_req_ready  input  1  memory interface accepts request
- rd_req_addr  output  ADDR_WIDTH  request line address
- rd_req_tag  output  TAG_WIDTH  request tag = issue index mod 2**TAG_WIDTH
- rd_rsp_valid  input  1  response valid; no backpressure
- rd_rsp_tag  input  TAG_WIDTH  response tag
- rd_rsp_data  input  512  response cache line
- input_fifo_din  output  512  line to input FIFO
- input_fifo_we  output  1  input FIFO write enable
- input_fifo_full  input  1  FIFO full
- input_fifo_count  input  BUFF_DEPTH_BITS  FIFO occupancy
- busy  output  1  job in progress
- done  output  1  one-cycle pulse at job completion

Behaviour:
- Reset (async, active low) values:
  - All outputs 0.
  - State = IDLE; all counters 0.
- Reset mid-job aborts the job. Responses arriving while in IDLE are dropped and never written to the FIFO.
- Start decode (in IDLE only):
  - start with ctx_length = 0: go to DONE.
  - start with ctx_length != 0: latch the address and length, clear counters, go to RUN.
  - start outside IDLE is ignored.
- RUN:
  - rd_req_valid = 1 when issued < length and (outstanding + input_fifo_count + 1) < 2**BUFF_DEPTH_BITS and !input_fifo_full.
  - outstanding is 1 + BUFF_DEPTH_BITS bits wide, so the sum cannot overflow.
  - The request transfers when rd_req_valid && rd_req_ready. On transfer: addr++ (wraps modulo 2**ADDR_WIDTH), tag++ (wraps), issued++, outstanding++.
  - Address, tag and valid are held stable while valid is high and ready is low.
  - When issued == length, go to DRAIN.
- DRAIN: wait until received == length and outstanding == 0, then go to DONE.
- DONE: assert done for exactly one cycle, then return to IDLE.
- busy = 1 in RUN and DRAIN.
- Response path (RUN or DRAIN):
  - rd_rsp_valid registers rd_rsp_data into input_fifo_din.
  - input_fifo_we is asserted the next cycle; latency is 1 cycle.
  - received++ on the response cycle.
  - outstanding-- on the input_fifo_we cycle, so a line in the pipeline register still holds its credit.
- Simultaneous request transfer and input_fifo_we in the same cycle: outstanding stays unchanged.
- The credit rule guarantees input_fifo_we is never asserted while input_fifo_full is high. This is asserted in simulation.
- ctx_length = 0xFFFFFFFF is legal; the counters are 32 bits wide.

Optional Feature:
- Macro: AFU_READ_TAG_CHECK_EN.
- When defined:
  - An expected-tag counter tracks the tag each in-order response should carry.
  - A mismatching response sets a sticky output tag_err (1 bit, reset 0, cleared on start).
  - The data is still written to the FIFO.
- When undefined: no tag_err port and no comparison logic; rd_rsp_tag is unused.

Decomposition:
- Shared package afu_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - CL_WIDTH = 512;
  - a rd_req_t struct {addr, tag} reused by the write engine.
- One natural sub-module, afu_credit_counter: the up/down outstanding counter with its credit-available compare.

Test Plan:
- Base 0x100, length 4, ready held 1, response 3 cycles after each request:
  - 4 requests with addr 0x100..0x103 and tags 0..3;
  - 4 FIFO writes, data in order;
  - one done pulse; busy low afterwards.
- Length 0: done pulses 2 cycles after start; no request and no FIFO write.
- Depth 8, input_fifo_count tied to 5, length 10, no responses returned: exactly 2 requests issue, then rd_req_valid stays 0.
- rd_req_ready low for 5 cycles with valid high: addr and tag held; one transfer occurs when ready rises.
- Base 0xFFFFFFFE, length 3: addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0.
- Reset asserted after 2 of 6 requests:
  - all outputs 0 immediately;
  - late responses produce no FIFO write;
  - a new start then runs cleanly.
  - With AFU_READ_TAG_CHECK_EN, a response with tag 5 when 2 is expected sets tag_err.
